// File: rtl/renorm_ctrl_pkg.sv
// Shared types and constants for the range-coder renormalisation controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package renorm_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_EMIT0 = 3'd2,
    S_EMIT1 = 3'd3,
    S_TAIL  = 3'd4
  } state_t;

  // Coder state after reset: half-full range, nine bits short of the first byte
  localparam logic        [15:0] RANGE_INIT = 16'h8000;
  localparam logic signed [31:0] CNT_INIT   = -32'sd9;

  // Offsets applied to the bit count when extracting bytes
  localparam logic signed [31:0] OFF_WORD = 32'sd16;
  localparam logic signed [31:0] OFF_BYTE = 32'sd8;
  localparam logic signed [31:0] OFF_CNT  = 32'sd24;

  // Emitted bytes carry one extra bit for the pending carry
  localparam int BYTE_W = 9;

endpackage

// File: rtl/renorm_ctrl_leading_zero.sv
// Leading-zero counter for the range word; an all-zero input reports RANGE_SIZE-1.
// Latency: combinational.
// Backpressure: none.
module leading_zero #(
  parameter int RANGE_SIZE = 16
) (
  input  logic [RANGE_SIZE-1:0]         i_val,
  output logic [$clog2(RANGE_SIZE)-1:0] o_cnt,
  output logic                          o_zero
);

  localparam int CW = $clog2(RANGE_SIZE);

  logic [CW-1:0] w_cnt;

  // Scan upward so the highest set bit has the final say
  always_comb begin
    w_cnt = CW'(RANGE_SIZE - 1);
    for (int i = 0; i < RANGE_SIZE; i++) begin
      if (i_val[i]) w_cnt = CW'(RANGE_SIZE - 1 - i);
    end
  end

  assign o_cnt  = w_cnt;
  assign o_zero = ~|i_val;

endmodule

// File: rtl/renorm_ctrl.sv
// Range-coder renormalisation: normalises low/range and emits 0, 1 or 2 carry bytes plus a frame tail.
// Latency: symbol accepted in cycle N, state and first output word visible at N+2.
// Backpressure: each output word holds until out_ready; no new symbol is accepted until all words drain.
module renorm_ctrl
  import renorm_ctrl_pkg::*;
#(
  parameter int DATA_16 = 16,
  parameter int DATA_32 = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_32-1:0]        in_low,
  input  logic [DATA_16-1:0]        in_range,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_16-1:0]        out_data,
  output logic                      out_tail,
  output logic                      out_last,
  output logic [DATA_32-1:0]        st_low,
  output logic [DATA_16-1:0]        st_range,
  output logic signed [DATA_32-1:0] st_cnt,
  output logic                      err
);

  localparam int                 D_W  = $clog2(DATA_16);
  localparam logic [DATA_32-1:0] ONE  = {{(DATA_32-1){1'b0}}, 1'b1};

  state_t                     r_state;
  logic [DATA_32-1:0]         r_in_low;
  logic [DATA_16-1:0]         r_in_range;
  logic                       r_in_last;
  logic [D_W-1:0]             r_d;
  logic [DATA_32-1:0]         r_st_low;
  logic [DATA_16-1:0]         r_st_range;
  logic signed [DATA_32-1:0]  r_st_cnt;
  logic [BYTE_W-1:0]          r_word1;
  logic                       r_two;
  logic                       r_out_valid;
  logic [DATA_16-1:0]         r_out_data;
  logic                       r_out_tail;
  logic                       r_out_last;
  logic                       r_err;

  logic [D_W-1:0]             w_lz;
  logic                       w_lz_zero;
  logic signed [DATA_32-1:0]  w_d32;
  logic signed [DATA_32-1:0]  w_s;
  logic signed [DATA_32-1:0]  w_c;
  logic signed [DATA_32-1:0]  w_cf;
  logic [DATA_32-1:0]         w_m;
  logic [DATA_32-1:0]         w_mf;
  logic                       w_emit;
  logic                       w_two;
  logic [BYTE_W-1:0]          w_word0;
  logic [BYTE_W-1:0]          w_word1;
  logic [DATA_32-1:0]         w_new_low;
  logic [DATA_16-1:0]         w_new_range;
  logic signed [DATA_32-1:0]  w_new_cnt;

  // Normalisation shift comes straight from the incoming range
  leading_zero #(
    .RANGE_SIZE(DATA_16)
  ) u_lz (
    .i_val  (in_range),
    .o_cnt  (w_lz),
    .o_zero (w_lz_zero)
  );

  // Byte extraction and next coder state, consumed only in CALC
  always_comb begin
    w_d32       = {{(DATA_32-D_W){1'b0}}, r_d};
    w_s         = r_st_cnt + w_d32;
    w_emit      = ~w_s[DATA_32-1];
    w_two       = (w_s >= OFF_BYTE);
    w_c         = r_st_cnt + OFF_WORD;
    w_m         = (ONE << w_c) - ONE;
    w_word0     = BYTE_W'(r_in_low >> w_c);
    w_word1     = BYTE_W'((r_in_low & w_m) >> (w_c - OFF_BYTE));
    w_cf        = w_two ? (w_c - OFF_BYTE) : w_c;
    w_mf        = w_two ? (w_m >> OFF_BYTE) : w_m;
    w_new_range = r_in_range << r_d;
    w_new_low   = w_emit ? ((r_in_low & w_mf) << r_d) : (r_in_low << r_d);
    w_new_cnt   = w_emit ? (w_cf + w_d32 - OFF_CNT) : w_s;
  end

  // Sequencer with registered outputs and coder state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_low    <= '0;
      r_in_range  <= '0;
      r_in_last   <= 1'b0;
      r_d         <= '0;
      r_st_low    <= '0;
      r_st_range  <= RANGE_INIT;
      r_st_cnt    <= CNT_INIT;
      r_word1     <= '0;
      r_two       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tail  <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_low   <= in_low;
            r_in_range <= in_range;
            r_in_last  <= in_last;
            r_d        <= w_lz;
            if (w_lz_zero) r_err <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_st_low   <= w_new_low;
          r_st_range <= w_new_range;
          r_st_cnt   <= w_new_cnt;
          if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {{(DATA_16-BYTE_W){1'b0}}, w_word0};
            r_word1     <= w_word1;
            r_two       <= w_two;
            r_state     <= S_EMIT0;
          end else if (r_in_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_new_low[DATA_32-1 -: DATA_16];
            r_out_tail  <= 1'b1;
            r_out_last  <= 1'b1;
            r_state     <= S_TAIL;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EMIT0: begin
          if (out_ready) begin
            if (r_two) begin
              r_out_data <= {{(DATA_16-BYTE_W){1'b0}}, r_word1};
              r_state    <= S_EMIT1;
            end else if (r_in_last) begin
              r_out_data <= r_st_low[DATA_32-1 -: DATA_16];
              r_out_tail <= 1'b1;
              r_out_last <= 1'b1;
              r_state    <= S_TAIL;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        S_EMIT1: begin
          if (out_ready) begin
            if (r_in_last) begin
              r_out_data <= r_st_low[DATA_32-1 -: DATA_16];
              r_out_tail <= 1'b1;
              r_out_last <= 1'b1;
              r_state    <= S_TAIL;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        S_TAIL: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_tail  <= 1'b0;
            r_out_last  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tail  = r_out_tail;
  assign out_last  = r_out_last;
  assign st_low    = r_st_low;
  assign st_range  = r_st_range;
  assign st_cnt    = r_st_cnt;
  assign err       = r_err;

endmodule

// File: doc/renorm_ctrl.md
RENORM_CTRL -- requirements
Module: renorm_ctrl

Interface
REQ-001 SHALL have parameter DATA_16, default 16, width of range and output word.
REQ-002 SHALL have parameter DATA_32, default 32, width of low accumulator and count.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  updated symbol state offered
- in_ready  out  1  controller accepts state
- in_low  in  32  un-normalised low after symbol update
- in_range  in  16  un-normalised range, nonzero
- in_last  in  1  final symbol of frame
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_data  out  16  pre-carry byte in bits [8:0], or tail word
- out_tail  out  1  out_data is tail word
- out_last  out  1  final word of frame
- st_low  out  32  normalised low, fed to upstream stages
- st_range  out  16  normalised range
- st_cnt  out  32  signed bit count
- err  out  1  sticky zero-range error

Function
REQ-004 SHALL run FSM IDLE, CALC, EMIT0, EMIT1, TAIL.
REQ-005 IDLE: in_ready=1; on in_valid&in_ready SHALL register in_low/in_range/in_last and d = leading zeros of in_range (0..15), then go to CALC.
REQ-006 CALC (1 cycle): s = st_cnt + d, signed 32-bit; if s<0, low<=low<<d, range<=range<<d, cnt<=s.
REQ-007 CALC with s>=0: c=cnt+16, m=(1<<c)-1. If s>=8: word0=low>>c, word1=(low&m)>>(c-8), c-=8, m>>=8, two words. Else word0=low>>c, one word.
REQ-008 CALC with s>=0 SHALL update low<=(low&m)<<d, range<=range<<d, cnt<=c+d-24.
REQ-009 Each emitted byte SHALL be truncated to 9 bits (bit 8 = carry), with out_data[15:9]=0.
REQ-010 CALC SHALL go to EMIT0 if words pending, else TAIL if last, else IDLE.
REQ-011 EMITn SHALL hold out_valid, out_data stable until out_ready; after word0 go to EMIT1 if two words, then TAIL if last, else IDLE.
REQ-012 TAIL SHALL emit out_data=st_low[31:16], out_tail=1, out_last=1, hold until out_ready, then IDLE.
REQ-013 out_last SHALL assert only on the tail word.
REQ-014 in_ready SHALL be 0 in every state except IDLE.
REQ-015 Latency: accept in cycle N; st_* update and first out_valid at N+2; no-emit symbol returns in_ready=1 at N+2.
REQ-016 in_range==0 SHALL set err (sticky until reset) and treat d=15.
REQ-017 in_range[15]=1 gives d=0, leaving range unchanged.
REQ-018 Shifts SHALL be 32-bit logical and discard overflow.

Reset
REQ-019 Reset SHALL force IDLE, st_low=0, st_range=16'h8000, st_cnt=-9, out_valid=0, out_tail=0, out_last=0, err=0, out_data=0.
REQ-020 Reset mid-emission SHALL discard pending words, with out_valid low in the next cycle.
REQ-021 in_ready SHALL be 0 while reset is asserted.

Structure
REQ-022 A shared package/header SHALL hold FSM state encodings, the init constants (8000h, -9), and the offsets 16, 8, 24.
REQ-023 Shall instantiate one sub-module, leading_zero (RANGE_SIZE=16), for d; the rest is inline.

Verification
REQ-024 Reset -> st_low=0, st_range=8000h, st_cnt=-9, out_valid=0, in_ready=1 in the first post-reset cycle.
REQ-025 cnt=-9, in_low=1234h, in_range=4000h -> no output; st_low=2468h, st_range=8000h, st_cnt=-8.
REQ-026 cnt=-1, in_low=12345h, in_range=4000h -> one word 002h; st_low=468Ah, st_cnt=-8.
REQ-027 cnt=-1, in_low=12345h, in_range=0040h -> words 002h then 046h; st_low=8A00h, st_range=8000h, st_cnt=-8.
REQ-028 REQ-027 case with out_ready low 5 cycles -> out_data held at 002h, in_ready=0, order preserved.
REQ-029 in_last on REQ-025 case -> tail word 0000h with out_tail=1, out_last=1; in_range=0 -> err=1 until reset.
